mipi_csi2_tx_packetizer: RTL and testbench
==========================================

# mipi_csi2_tx_packetizer

Converts a line-oriented 32-bit pixel stream into MIPI CSI-2 packets on a 4-lane byte-parallel bus. It is the transmit-side counterpart of the camera receive path. Per frame it emits a Frame Start short packet, one long packet per line (header with ECC, payload, CRC-16 footer) and a Frame End short packet. Output feeds a 4-lane HS serializer for loopback, sensor emulation and receiver self-test.

## Interface
- g_VC, 2'd0: virtual channel placed in every Data ID.
- g_DT, 6'h2B: long-packet data type (RAW10).
- g_WORD_COUNT, 16'd2600: payload bytes per line; multiple of 4, ≥4.
- g_GAP_CYCLES, 8: idle cycles forced after every packet (LP/HS-exit emulation); ≥1.
- CLK_I  in  1  byte clock; the only clock.
- RESETN_I  in  1  synchronous, active-low reset.
- FRAME_START_I  in  1  one-cycle request for Frame Start.
- FRAME_END_I  in  1  one-cycle request for Frame End.
- DATA_I  in  32  payload word; byte 0 = [7:0] goes first.
- DATA_VALID_I  in  1  payload word valid.
- DATA_LAST_I  in  1  marks last word of a line.
- DATA_READY_O  out  1  payload word accepted when high with DATA_VALID_I.
- HS_DATA_O  out  32  lane n byte = [8n+7:8n].
- HS_LANE_EN_O  out  4  per-lane byte valid.
- HS_SOT_O  out  1  first cycle of a packet.
- HS_EOT_O  out  1  last cycle of a packet.
- FRAME_ACTIVE_O  out  1  high from FS emission until FE emission.
- LINE_ERR_O  out  1  one-cycle pulse on a line-length or underflow error.

## Operation
- States: IDLE, SP_HDR, LP_HDR, LP_PAY, LP_FTR, GAP.
- Pending flags fs_pend and fe_pend are set by the request inputs and cleared when their header is emitted. Both asserted together → FS_I is ignored and fe_pend is set.
- IDLE priority:
  - fe_pend, only when FRAME_ACTIVE_O is high: go to SP_HDR with DT 0x01.
  - fs_pend, only when FRAME_ACTIVE_O is low: go to SP_HDR with DT 0x00.
  - DATA_VALID_I with FRAME_ACTIVE_O high: go to LP_HDR.
  - DATA_VALID_I with the frame inactive is neither accepted nor dropped; it stays pending.
- Short packet: bytes {VC,DT}, frame_num[7:0], frame_num[15:8], ECC. Lane enable 1111; SOT and EOT are both asserted on the same cycle.
- frame_num: reset value 1. Increments after each FE. After 0xFFFF it wraps to 1; 0 is never sent.
- Long header: {g_VC,g_DT}, WC[7:0], WC[15:8], ECC.
- ECC: CSI-2 v1.x 6-bit Hamming over the 24-bit header. ECC[7:6]=0.
- LP_PAY: N=g_WORD_COUNT/4 words, output verbatim with lane enable 1111.
  - CRC-16 runs over the payload bytes: polynomial x^16+x^12+x^5+1, reflected, init 0xFFFF, byte 0 first, four bytes per cycle.
- LP_FTR: lane0=CRC[7:0], lane1=CRC[15:8], lane enable 0011, EOT asserted.
- DATA_LAST_I seen before word N, or missing on word N → LINE_ERR_O pulses. The packet still carries exactly N words.
  - Early last: the remaining words are sent as 0x00.
  - Missing last: input words beyond N stay pending as the next line.
- DATA_VALID_I low during LP_PAY (underflow): that slot sends 0x00000000, CRC includes those zeros, and LINE_ERR_O pulses once per line. The HS stream never stalls.
- GAP: HS_LANE_EN_O is 0 for g_GAP_CYCLES cycles, then the block returns to IDLE.
- FE is emitted only from IDLE, so a line in progress always completes first.

## Timing
- Reset values: all outputs 0; state IDLE; frame_num 1; pending flags 0; CRC 0xFFFF.
- All HS_* outputs are registered.
- Decision in IDLE at cycle t → header on HS_DATA_O at t+1.
- DATA_READY_O is high at cycles t+1..t+N, combinationally from state and count. A word accepted at cycle k appears at k+1.
- Footer appears at t+N+2.
- First cycle of the gap is t+N+3; next header no earlier than t+N+3+g_GAP_CYCLES.
- Short packet: header at t+1; next header no earlier than t+2+g_GAP_CYCLES.
- FRAME_ACTIVE_O rises on the FS header cycle and falls on the FE header cycle.
- Reset mid-packet: the packet is aborted and the block is in IDLE next cycle with no EOT.

## Structure
- Package mipi_csi2_pkg: DT constants (FS 0x00, FE 0x01, RAW8 0x2A, RAW10 0x2B), state enum, functions csi2_ecc(24b)→6b and csi2_crc16_byte.
- Sub-module mipi_csi2_crc16_x4: 32-bit-per-cycle CRC with init/enable. It is shared with the receive checker.

## Test plan
- All-zero header (DI 0x00, WC 0x0000) → ECC byte 0x00. FS after reset → lanes 00,01,00,ECC; SOT=EOT=1; FRAME_ACTIVE_O rises.
- g_WORD_COUNT=24, payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01 → footer lanes F0,00; lane enable 0011; DATA_READY_O high exactly 6 cycles.
- DATA_VALID_I dropped for one cycle mid-line → that slot is 0x00000000, one LINE_ERR_O pulse, footer at the same cycle as the error-free case.
- FRAME_END_I asserted during LP_PAY → current line completes, g_GAP_CYCLES idle cycles, then FE with frame_num 1; the next FS carries 2.
- Frame number starting at 0xFFFF → after FE the next FS carries 0x0001.
- RESETN_I low in the middle of LP_PAY → all outputs 0 next cycle; a following FS produces a clean packet with ECC correct.

Source files
------------

// File: rtl/mipi_csi2_pkg.sv
// Shared CSI-2 definitions: data types, FSM encodings, header ECC and payload CRC helpers.
// Used by the transmit packetizer and the receive-side checker.
package mipi_csi2_pkg;

    localparam logic [5:0] DT_FS    = 6'h00;
    localparam logic [5:0] DT_FE    = 6'h01;
    localparam logic [5:0] DT_RAW8  = 6'h2A;
    localparam logic [5:0] DT_RAW10 = 6'h2B;

    typedef logic [2:0] csi2_state_t;

    localparam csi2_state_t ST_IDLE   = 3'd0;
    localparam csi2_state_t ST_SP_HDR = 3'd1;
    localparam csi2_state_t ST_LP_HDR = 3'd2;
    localparam csi2_state_t ST_LP_PAY = 3'd3;
    localparam csi2_state_t ST_LP_FTR = 3'd4;
    localparam csi2_state_t ST_GAP    = 3'd5;

    // Each mask selects the header bits that feed one Hamming parity bit.
    function automatic logic [5:0] csi2_ecc(input logic [23:0] hdr);
        logic [5:0] p;
        p[0] = ^(hdr & 24'hF12CB7);
        p[1] = ^(hdr & 24'hF2555B);
        p[2] = ^(hdr & 24'h749A6D);
        p[3] = ^(hdr & 24'hB8E38E);
        p[4] = ^(hdr & 24'hDF03F0);
        p[5] = ^(hdr & 24'hEFFC00);
        return p;
    endfunction

    // Reflected CCITT polynomial (0x8408), one byte, LSB first.
    function automatic logic [15:0] csi2_crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/mipi_csi2_crc16_x4.sv
// CSI-2 payload CRC-16 consuming one 32-bit word (four bytes, byte 0 first) per enabled cycle.
module mipi_csi2_crc16_x4
    import mipi_csi2_pkg::*;
(
    input  logic        CLK_I,
    input  logic        RESETN_I,
    input  logic        INIT_I,
    input  logic        EN_I,
    input  logic [31:0] DATA_I,
    output logic [15:0] CRC_O
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (INIT_I) begin
            crc_d = 16'hFFFF;
        end else if (EN_I) begin
            crc_d = csi2_crc16_byte(crc_d, DATA_I[7:0]);
            crc_d = csi2_crc16_byte(crc_d, DATA_I[15:8]);
            crc_d = csi2_crc16_byte(crc_d, DATA_I[23:16]);
            crc_d = csi2_crc16_byte(crc_d, DATA_I[31:24]);
        end
    end

    always_ff @(posedge CLK_I) begin
        if (!RESETN_I) begin
            crc_q <= 16'hFFFF;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign CRC_O = crc_q;

endmodule

// File: rtl/mipi_csi2_tx_packetizer.sv
// Line-oriented pixel stream to CSI-2 FS/long/FE packets on a 4-lane byte-parallel HS bus.
// State names the phase currently visible on the registered HS outputs.
module mipi_csi2_tx_packetizer
    import mipi_csi2_pkg::*;
#(
    parameter logic [1:0]  g_VC             = 2'd0,
    parameter logic [5:0]  g_DT             = DT_RAW10,
    parameter logic [15:0] g_WORD_COUNT     = 16'd2600,
    parameter int          g_GAP_CYCLES     = 8,
    parameter logic [15:0] g_FRAME_NUM_INIT = 16'd1
) (
    input  logic        CLK_I,
    input  logic        RESETN_I,
    input  logic        FRAME_START_I,
    input  logic        FRAME_END_I,
    input  logic [31:0] DATA_I,
    input  logic        DATA_VALID_I,
    input  logic        DATA_LAST_I,
    output logic        DATA_READY_O,
    output logic [31:0] HS_DATA_O,
    output logic [3:0]  HS_LANE_EN_O,
    output logic        HS_SOT_O,
    output logic        HS_EOT_O,
    output logic        FRAME_ACTIVE_O,
    output logic        LINE_ERR_O,
    output logic [2:0]  DBG_STATE_O
);

    localparam logic [15:0] N_WORDS  = g_WORD_COUNT >> 2;
    localparam logic [15:0] GAP_LAST = 16'(g_GAP_CYCLES - 1);

    csi2_state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] gap_q, gap_d;
    logic [15:0] frame_num_q, frame_num_d;
    logic        fs_pend_q, fs_pend_d;
    logic        fe_pend_q, fe_pend_d;
    logic        active_q, active_d;
    logic        done_q, done_d;
    logic        err_seen_q, err_seen_d;
    logic [31:0] hs_data_q, hs_data_d;
    logic [3:0]  hs_en_q, hs_en_d;
    logic        sot_q, sot_d;
    logic        eot_q, eot_d;
    logic        line_err_q, line_err_d;

    logic        slot;
    logic        take;
    logic        last_slot;
    logic        err_now;
    logic        crc_init;
    logic [31:0] slot_word;
    logic [15:0] crc;
    logic [23:0] fs_hdr, fe_hdr, lp_hdr;

    assign fs_hdr = {frame_num_q, g_VC, DT_FS};
    assign fe_hdr = {frame_num_q, g_VC, DT_FE};
    assign lp_hdr = {g_WORD_COUNT, g_VC, g_DT};

    // A payload slot exists on the header cycle and each payload cycle until N words are out.
    assign slot         = (state_q == ST_LP_HDR) || ((state_q == ST_LP_PAY) && (cnt_q != N_WORDS));
    assign DATA_READY_O = slot && !done_q;
    assign take         = DATA_READY_O && DATA_VALID_I;
    assign last_slot    = (cnt_q == N_WORDS - 16'd1);
    assign slot_word    = take ? DATA_I : 32'h0000_0000;

    mipi_csi2_crc16_x4 u_crc (
        .CLK_I    (CLK_I),
        .RESETN_I (RESETN_I),
        .INIT_I   (crc_init),
        .EN_I     (slot),
        .DATA_I   (slot_word),
        .CRC_O    (crc)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        frame_num_d = frame_num_q;
        fs_pend_d   = fs_pend_q;
        fe_pend_d   = fe_pend_q;
        active_d    = active_q;
        done_d      = done_q;
        err_seen_d  = err_seen_q;
        hs_data_d   = 32'h0000_0000;
        hs_en_d     = 4'b0000;
        sot_d       = 1'b0;
        eot_d       = 1'b0;
        line_err_d  = 1'b0;
        crc_init    = 1'b0;
        err_now     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fe_pend_q && active_q) begin
                    hs_data_d   = {2'b00, csi2_ecc(fe_hdr), fe_hdr};
                    hs_en_d     = 4'b1111;
                    sot_d       = 1'b1;
                    eot_d       = 1'b1;
                    fe_pend_d   = 1'b0;
                    active_d    = 1'b0;
                    frame_num_d = (frame_num_q == 16'hFFFF) ? 16'd1 : frame_num_q + 16'd1;
                    state_d     = ST_SP_HDR;
                end else if (fs_pend_q && !active_q) begin
                    hs_data_d = {2'b00, csi2_ecc(fs_hdr), fs_hdr};
                    hs_en_d   = 4'b1111;
                    sot_d     = 1'b1;
                    eot_d     = 1'b1;
                    fs_pend_d = 1'b0;
                    active_d  = 1'b1;
                    state_d   = ST_SP_HDR;
                end else if (DATA_VALID_I && active_q) begin
                    hs_data_d  = {2'b00, csi2_ecc(lp_hdr), lp_hdr};
                    hs_en_d    = 4'b1111;
                    sot_d      = 1'b1;
                    crc_init   = 1'b1;
                    cnt_d      = 16'd0;
                    done_d     = 1'b0;
                    err_seen_d = 1'b0;
                    state_d    = ST_LP_HDR;
                end
            end
            ST_SP_HDR, ST_LP_FTR: begin
                gap_d   = 16'd0;
                state_d = ST_GAP;
            end
            ST_LP_HDR, ST_LP_PAY: begin
                if (slot) begin
                    hs_data_d = slot_word;
                    hs_en_d   = 4'b1111;
                    cnt_d     = cnt_q + 16'd1;
                    state_d   = ST_LP_PAY;
                    // Once an early last is seen the rest of the line is zero-filled, not underflow.
                    if (take && DATA_LAST_I && !last_slot) begin
                        done_d  = 1'b1;
                        err_now = 1'b1;
                    end
                    if (take && !DATA_LAST_I && last_slot) err_now = 1'b1;
                    if (!take && !done_q) err_now = 1'b1;
                    if (err_now && !err_seen_q) begin
                        line_err_d = 1'b1;
                        err_seen_d = 1'b1;
                    end
                end else begin
                    hs_data_d = {16'h0000, crc};
                    hs_en_d   = 4'b0011;
                    eot_d     = 1'b1;
                    state_d   = ST_LP_FTR;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A simultaneous start and end request is treated as an end request only.
        if (FRAME_END_I) begin
            fe_pend_d = 1'b1;
        end else if (FRAME_START_I) begin
            fs_pend_d = 1'b1;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (!RESETN_I) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            gap_q       <= 16'd0;
            frame_num_q <= g_FRAME_NUM_INIT;
            fs_pend_q   <= 1'b0;
            fe_pend_q   <= 1'b0;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            err_seen_q  <= 1'b0;
            hs_data_q   <= 32'h0000_0000;
            hs_en_q     <= 4'b0000;
            sot_q       <= 1'b0;
            eot_q       <= 1'b0;
            line_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            frame_num_q <= frame_num_d;
            fs_pend_q   <= fs_pend_d;
            fe_pend_q   <= fe_pend_d;
            active_q    <= active_d;
            done_q      <= done_d;
            err_seen_q  <= err_seen_d;
            hs_data_q   <= hs_data_d;
            hs_en_q     <= hs_en_d;
            sot_q       <= sot_d;
            eot_q       <= eot_d;
            line_err_q  <= line_err_d;
        end
    end

    assign HS_DATA_O      = hs_data_q;
    assign HS_LANE_EN_O   = hs_en_q;
    assign HS_SOT_O       = sot_q;
    assign HS_EOT_O       = eot_q;
    assign FRAME_ACTIVE_O = active_q;
    assign LINE_ERR_O     = line_err_q;
    assign DBG_STATE_O    = state_q;

endmodule

// File: tb/tb_mipi_csi2_tx_packetizer.sv
// Scoreboard bench for the CSI-2 packetizer: expected HS beats are queued as stimulus is driven
// and compared as the DUT emits them. A second instance starts its frame counter at 0xFFFF.
module tb_mipi_csi2_tx_packetizer;

    localparam int N = 6;
    localparam int G = 4;

    logic        clk;
    logic        resetn;
    logic        fs_i, fe_i, fs2_i, fe2_i;
    logic [31:0] data_i;
    logic        valid_i, last_i;
    logic        ready_o;
    logic [31:0] hs_data_o;
    logic [3:0]  hs_en_o;
    logic        sot_o, eot_o, fa_o, err_o;
    logic [2:0]  st_o;
    logic [31:0] hs2_data_o;
    logic [3:0]  hs2_en_o;
    logic        sot2_o, eot2_o, fa2_o, err2_o, rdy2_o;
    logic [2:0]  st2_o;

    logic [37:0] exp_q[$];
    logic [37:0] exp2_q[$];
    logic [31:0] gold[6];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hdr_cyc = 0;
    int rdy_cnt = 0;
    int err_cnt = 0;
    int gap_left = 0;
    bit gap_bad = 0;
    bit inst2_noise = 0;

    mipi_csi2_tx_packetizer #(
        .g_VC(2'd0), .g_DT(6'h2B), .g_WORD_COUNT(16'd24), .g_GAP_CYCLES(G)
    ) dut (
        .CLK_I(clk), .RESETN_I(resetn), .FRAME_START_I(fs_i), .FRAME_END_I(fe_i),
        .DATA_I(data_i), .DATA_VALID_I(valid_i), .DATA_LAST_I(last_i), .DATA_READY_O(ready_o),
        .HS_DATA_O(hs_data_o), .HS_LANE_EN_O(hs_en_o), .HS_SOT_O(sot_o), .HS_EOT_O(eot_o),
        .FRAME_ACTIVE_O(fa_o), .LINE_ERR_O(err_o), .DBG_STATE_O(st_o)
    );

    mipi_csi2_tx_packetizer #(
        .g_VC(2'd0), .g_DT(6'h2B), .g_WORD_COUNT(16'd24), .g_GAP_CYCLES(G),
        .g_FRAME_NUM_INIT(16'hFFFF)
    ) dut_wrap (
        .CLK_I(clk), .RESETN_I(resetn), .FRAME_START_I(fs2_i), .FRAME_END_I(fe2_i),
        .DATA_I(32'h0), .DATA_VALID_I(1'b0), .DATA_LAST_I(1'b0), .DATA_READY_O(rdy2_o),
        .HS_DATA_O(hs2_data_o), .HS_LANE_EN_O(hs2_en_o), .HS_SOT_O(sot2_o), .HS_EOT_O(eot2_o),
        .FRAME_ACTIVE_O(fa2_o), .LINE_ERR_O(err2_o), .DBG_STATE_O(st2_o)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference models ----------------
    function automatic logic [5:0] ecc_model(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    function automatic logic [15:0] crc_word(input logic [15:0] crc, input logic [31:0] w);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 32; i++) begin
            fb = c[0] ^ w[i];
            c  = c >> 1;
            if (fb) c = c ^ 16'h8408;
        end
        return c;
    endfunction

    function automatic logic [37:0] sp_beat(input logic [5:0] dt, input logic [15:0] fn);
        logic [23:0] h;
        h = {fn, 2'b00, dt};
        return {1'b1, 1'b1, 4'hF, 2'b00, ecc_model(h), h};
    endfunction

    function automatic logic [37:0] lp_hdr_beat();
        logic [23:0] h;
        h = {16'd24, 2'b00, 6'h2B};
        return {1'b1, 1'b0, 4'hF, 2'b00, ecc_model(h), h};
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        logic [37:0] beat;
        logic [37:0] e;
        cyc++;
        beat = {sot_o, eot_o, hs_en_o, hs_data_o};
        if (err_o) err_cnt++;
        if (gap_left > 0) begin
            if (hs_en_o != 4'h0) gap_bad = 1'b1;
            gap_left--;
            if (gap_left == 0) check("gap_idle", 64'(gap_bad), 64'd0);
        end
        if (sot_o && !eot_o) begin
            hdr_cyc = cyc;
            rdy_cnt = ready_o ? 1 : 0;
        end else if (ready_o) begin
            rdy_cnt++;
        end
        if (eot_o && hs_en_o == 4'h3) begin
            check("ready_cycles", 64'(rdy_cnt), 64'(N));
            check("ftr_latency", 64'(cyc - hdr_cyc), 64'(N + 1));
        end
        if (sot_o && eot_o) begin
            if (hs_data_o[5:0] == 6'h00) check("fa_at_fs", 64'(fa_o), 64'd1);
            else check("fa_at_fe", 64'(fa_o), 64'd0);
        end
        if (eot_o) begin
            gap_left = G;
            gap_bad  = 1'b0;
        end
        if (hs_en_o != 4'h0) begin
            if (exp_q.size() == 0) begin
                check("unexp_beat", 64'(beat), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("hs_beat", 64'(beat), 64'(e));
            end
        end
    end

    always @(negedge clk) begin
        logic [37:0] e;
        if (err2_o || rdy2_o) inst2_noise = 1'b1;
        if (hs2_en_o != 4'h0) begin
            if (exp2_q.size() == 0) begin
                check("wrap_unexp", 64'({sot2_o, eot2_o, hs2_en_o, hs2_data_o}), 64'd0);
            end else begin
                e = exp2_q.pop_front();
                check("wrap_beat", 64'({sot2_o, eot2_o, hs2_en_o, hs2_data_o}), 64'(e));
                if (hs2_data_o[5:0] == 6'h01) check("wrap_fa_at_fe", 64'(fa2_o), 64'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse(input int which);
        case (which)
            0: fs_i = 1'b1;
            1: fe_i = 1'b1;
            2: fs2_i = 1'b1;
            default: fe2_i = 1'b1;
        endcase
        @(posedge clk); #1;
        fs_i = 1'b0; fe_i = 1'b0; fs2_i = 1'b0; fe2_i = 1'b0;
    endtask

    task automatic wait_drain();
        int b;
        b = 0;
        while ((exp_q.size() != 0 || exp2_q.size() != 0) && b < 300) begin
            @(posedge clk); #1;
            b++;
        end
        check("drain", 64'(exp_q.size() + exp2_q.size()), 64'd0);
        repeat (G + 3) @(posedge clk);
        #1;
    endtask

    // drop_at >= 1: one underflow cycle in that slot (N-1 real words, last on the final one).
    // fe_at >= 0: pulse FRAME_END_I while that word is presented.
    task automatic send_line(input int drop_at, input int fe_at, input bit golden);
        logic [31:0] w[$];
        logic [31:0] p[$];
        logic [15:0] crc;
        int          nw, idx, budget;
        bit          dropped, fe_sent;
        logic        r;
        nw = (drop_at >= 0) ? N - 1 : N;
        for (int i = 0; i < nw; i++) w.push_back(golden ? gold[i] : $urandom());
        for (int i = 0; i < nw; i++) begin
            if (i == drop_at) p.push_back(32'h0);
            p.push_back(w[i]);
        end
        crc = 16'hFFFF;
        for (int i = 0; i < N; i++) crc = crc_word(crc, p[i]);
        if (golden) crc = 16'h00F0;
        exp_q.push_back(lp_hdr_beat());
        for (int i = 0; i < N; i++) exp_q.push_back({2'b00, 4'hF, p[i]});
        exp_q.push_back({1'b0, 1'b1, 4'h3, 16'h0000, crc});

        idx = 0; budget = 0; dropped = 0; fe_sent = 0;
        while (idx < nw && budget < 200) begin
            budget++;
            if (idx == fe_at && !fe_sent) begin
                fe_i    = 1'b1;
                fe_sent = 1;
            end else begin
                fe_i = 1'b0;
            end
            if (drop_at >= 0 && idx == drop_at && !dropped) begin
                valid_i = 1'b0;
                dropped = 1;
                @(posedge clk); #1;
            end else begin
                valid_i = 1'b1;
                data_i  = w[idx];
                last_i  = (idx == nw - 1);
                @(negedge clk);
                r = ready_o;
                @(posedge clk); #1;
                if (r) idx++;
            end
        end
        valid_i = 1'b0; last_i = 1'b0; fe_i = 1'b0;
        check("line_words_taken", 64'(idx), 64'(nw));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int e0, b;
        bit rdy_any;
        gold[0] = 32'h020000FF; gold[1] = 32'h72F3DCB9; gold[2] = 32'h5AB8D4BB;
        gold[3] = 32'h7CC275C8; gold[4] = 32'hDF05F881; gold[5] = 32'h010000FF;
        resetn = 1'b0; fs_i = 0; fe_i = 0; fs2_i = 0; fe2_i = 0;
        data_i = 32'h0; valid_i = 0; last_i = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {25'h0, sot_o, eot_o, hs_en_o, hs_data_o, fa_o, err_o, ready_o}, 64'd0);
        check("reset_state", 64'(st_o), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Frame start after reset carries frame number 1.
        exp_q.push_back(sp_beat(6'h00, 16'd1));
        pulse(0);
        wait_drain();

        // Golden payload with known CRC 0x00F0.
        e0 = err_cnt;
        send_line(-1, -1, 1'b1);
        wait_drain();
        check("golden_line_err", 64'(err_cnt - e0), 64'd0);

        // Underflow in slot 2.
        e0 = err_cnt;
        send_line(2, -1, 1'b0);
        wait_drain();
        check("underflow_err", 64'(err_cnt - e0), 64'd1);

        // Frame end requested mid-line: line completes, then FE with frame 1.
        e0 = err_cnt;
        send_line(-1, 3, 1'b0);
        exp_q.push_back(sp_beat(6'h01, 16'd1));
        wait_drain();
        check("fe_line_err", 64'(err_cnt - e0), 64'd0);
        check("fa_after_fe", 64'(fa_o), 64'd0);

        // Data while no frame is active is held off until FS, which carries frame 2.
        valid_i = 1'b1; data_i = 32'h1234_5678;
        rdy_any = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ready_o) rdy_any = 1;
            @(posedge clk); #1;
        end
        check("inactive_no_ready", 64'(rdy_any), 64'd0);
        exp_q.push_back(sp_beat(6'h00, 16'd2));
        pulse(0);
        e0 = err_cnt;
        send_line(-1, -1, 1'b0);
        wait_drain();
        check("pending_line_err", 64'(err_cnt - e0), 64'd0);

        // Reset in the middle of the payload.
        exp_q.push_back(lp_hdr_beat());
        for (int i = 0; i < 3; i++) exp_q.push_back({2'b00, 4'hF, 32'hA5A5_0F0F});
        valid_i = 1'b1; data_i = 32'hA5A5_0F0F; last_i = 1'b0;
        b = 0;
        while (exp_q.size() != 1 && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        check("mid_line_reached", 64'(exp_q.size()), 64'd1);
        resetn = 1'b0;
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs", {25'h0, sot_o, eot_o, hs_en_o, hs_data_o, fa_o, err_o, ready_o}, 64'd0);
        check("rst_mid_state", 64'(st_o), 64'd0);
        check("rst_mid_flushed", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(sp_beat(6'h00, 16'd1));
        pulse(0);
        wait_drain();

        // Frame number wrap on the second instance: FFFF, FFFF, then 0001.
        exp2_q.push_back(sp_beat(6'h00, 16'hFFFF));
        pulse(2);
        wait_drain();
        exp2_q.push_back(sp_beat(6'h01, 16'hFFFF));
        pulse(3);
        wait_drain();
        exp2_q.push_back(sp_beat(6'h00, 16'h0001));
        pulse(2);
        wait_drain();
        check("wrap_quiet", 64'(inst2_noise), 64'd0);
        check("wrap_idle_state", 64'(st2_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
